// File: rtl/exe_forward_sched.sv
// Execute-stage scheduler: tracks in-flight destination registers and
// produces the registered EXE operand-forwarding selects plus the
// stall/bubble controls for load-use and RAW hazards.
// Forward select encoding: 0 = register file, 1 = MEM ALU result, 2 = WB result.
module exe_forward_sched #(
  parameter int REG_AW          = 5,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic              pipe_freeze,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic              id_wb_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_mem_read,
  output logic [1:0]        src1_decider,
  output logic [1:0]        src2_decider,
  output logic              stall,
  output logic              bubble
);

  typedef enum logic [1:0] {RUN, LU_STALL, RAW_STALL} state_t;

  // Counter reload after the first load-use bubble; the first bubble is the hazard cycle itself.
  localparam logic [1:0] LU_LOAD = 2'(LU_STALL_CYCLES - 1);

  state_t            state, state_next;
  logic [1:0]        lu_cnt, lu_cnt_next;

  // The WB stage is not stored: the register file writes before it is read,
  // so an instruction in WB can never cause a hazard or need a forward.
  logic              ex_valid, ex_wb_en, ex_mem_read;
  logic [REG_AW-1:0] ex_dest;
  logic              mem_valid, mem_wb_en;
  logic [REG_AW-1:0] mem_dest;

  logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic              ex_hit, mem_hit;
  logic              hazard, enter;
  logic [1:0]        fwd1, fwd2;

  // Source-to-stage match detection; register 0 is never a producer.
  always_comb begin
    ex_hit1  = ex_valid && ex_wb_en && (ex_dest != '0) && (ex_dest == id_src1);
    ex_hit2  = ex_valid && ex_wb_en && (ex_dest != '0) && (ex_dest == id_src2) && id_src2_used;
    mem_hit1 = mem_valid && mem_wb_en && (mem_dest != '0) && (mem_dest == id_src1);
    mem_hit2 = mem_valid && mem_wb_en && (mem_dest != '0) && (mem_dest == id_src2) && id_src2_used;
    ex_hit   = id_valid && (ex_hit1 || ex_hit2);
    mem_hit  = id_valid && (mem_hit1 || mem_hit2);
    fwd1     = ex_hit1 ? 2'd1 : (mem_hit1 ? 2'd2 : 2'd0);
    fwd2     = ex_hit2 ? 2'd1 : (mem_hit2 ? 2'd2 : 2'd0);
  end

  // Next-state and hazard logic; LU_STALL with an expired counter and
  // RAW_STALL both fall through to a fresh RUN evaluation in the same cycle.
  always_comb begin
    state_next  = state;
    lu_cnt_next = lu_cnt;
    hazard      = 1'b0;
    if (state == LU_STALL && lu_cnt != 2'd0) begin
      hazard      = 1'b1;
      lu_cnt_next = lu_cnt - 2'd1;
    end else begin
      state_next  = RUN;
      lu_cnt_next = 2'd0;
      if (fwd_en) begin
        if (ex_hit && ex_mem_read) begin
          hazard      = 1'b1;
          state_next  = LU_STALL;
          lu_cnt_next = LU_LOAD;
        end
      end else if (ex_hit || mem_hit) begin
        hazard     = 1'b1;
        state_next = RAW_STALL;
      end
    end
    enter  = id_valid && !hazard;
    stall  = rst && (pipe_freeze || hazard);
    bubble = rst && !pipe_freeze && hazard;
  end

  // FSM state and load-use counter register; frozen pipeline holds them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      lu_cnt <= 2'd0;
    end else if (!pipe_freeze) begin
      state  <= state_next;
      lu_cnt <= lu_cnt_next;
    end
  end

  // Tracking pipe and forwarding selects advance together with the real pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_wb_en     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_dest      <= '0;
      mem_valid    <= 1'b0;
      mem_wb_en    <= 1'b0;
      mem_dest     <= '0;
      src1_decider <= 2'd0;
      src2_decider <= 2'd0;
    end else if (!pipe_freeze) begin
      mem_valid    <= ex_valid;
      mem_wb_en    <= ex_wb_en;
      mem_dest     <= ex_dest;
      ex_valid     <= enter;
      ex_wb_en     <= id_wb_en;
      ex_mem_read  <= id_mem_read;
      ex_dest      <= id_dest;
      src1_decider <= (enter && fwd_en) ? fwd1 : 2'd0;
      src2_decider <= (enter && fwd_en) ? fwd2 : 2'd0;
    end
  end

endmodule

// File: tb/tb_exe_forward_sched.sv
// Directed testbench for exe_forward_sched with hand-computed expectations.
module tb_exe_forward_sched;

  logic       clk;
  logic       rst;
  logic       fwd_en;
  logic       pipe_freeze;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_src2_used;
  logic       id_wb_en;
  logic [4:0] id_dest;
  logic       id_mem_read;
  logic [1:0] src1_decider;
  logic [1:0] src2_decider;
  logic       stall;
  logic       bubble;

  int checkCount;
  int errorCount;

  exe_forward_sched #(.REG_AW(5), .LU_STALL_CYCLES(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_en       (fwd_en),
    .pipe_freeze  (pipe_freeze),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src2_used (id_src2_used),
    .id_wb_en     (id_wb_en),
    .id_dest      (id_dest),
    .id_mem_read  (id_mem_read),
    .src1_decider (src1_decider),
    .src2_decider (src2_decider),
    .stall        (stall),
    .bubble       (bubble)
  );

  // Free-running clock, rising edge active
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one ID-stage instruction on the falling edge, then settle
  task automatic applyStimulus(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                               input logic s2u, input logic we, input logic [4:0] d,
                               input logic mr);
    @(negedge clk);
    id_valid     = v;
    id_src1      = s1;
    id_src2      = s2;
    id_src2_used = s2u;
    id_wb_en     = we;
    id_dest      = d;
    id_mem_read  = mr;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHazard(input string tag, input logic s, input logic b);
    checkOutput({tag, "_stall"}, stall, s);
    checkOutput({tag, "_bubble"}, bubble, b);
  endtask

  task automatic checkDeciders(input string tag, input logic [1:0] d1, input logic [1:0] d2);
    checkOutput({tag, "_src1"}, src1_decider, d1);
    checkOutput({tag, "_src2"}, src2_decider, d2);
  endtask

  // Empty the tracking pipe with invalid slots
  task automatic flushPipe();
    repeat (3) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      stepClock();
    end
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    rst          = 1'b0;
    fwd_en       = 1'b1;
    pipe_freeze  = 1'b0;
    id_valid     = 1'b0;
    id_src1      = '0;
    id_src2      = '0;
    id_src2_used = 1'b0;
    id_wb_en     = 1'b0;
    id_dest      = '0;
    id_mem_read  = 1'b0;

    // Reset state
    #12;
    checkHazard("reset", 1'b0, 1'b0);
    checkDeciders("reset", 2'd0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    flushPipe();

    // Distance-1 forwarding: ADD r3; SUB r3, r7
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
    checkHazard("d1_add", 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0);
    checkHazard("d1_sub", 1'b0, 1'b0);
    stepClock();
    checkDeciders("d1", 2'd1, 2'd0);
    flushPipe();
    checkDeciders("d1_flush", 2'd0, 2'd0);

    // Distance-2 forwarding on src2: ADD r4; unrelated; OR r12, r4
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd12, 5'd4, 1'b1, 1'b1, 5'd13, 1'b0);
    checkHazard("d2_or", 1'b0, 1'b0);
    stepClock();
    checkDeciders("d2", 2'd0, 2'd2);
    flushPipe();

    // Immediate src2 ignores a matching register field
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd9, 5'd4, 1'b0, 1'b1, 5'd13, 1'b0);
    stepClock();
    checkDeciders("imm", 2'd0, 2'd0);
    flushPipe();

    // r0 destination never forwards
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b0);
    stepClock();
    checkDeciders("r0", 2'd0, 2'd0);
    flushPipe();

    // Load-use: LW r5; ADD r5, r6 -> one bubble then WB forward
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1);
    stepClock();
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b0);
    checkHazard("lu_hit", 1'b1, 1'b1);
    stepClock();
    checkDeciders("lu_bubble", 2'd0, 2'd0);
    checkHazard("lu_release", 1'b0, 1'b0);
    stepClock();
    checkDeciders("lu_enter", 2'd2, 2'd0);
    flushPipe();

    // Invalid ID slot behind a load raises no hazard
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1);
    stepClock();
    applyStimulus(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b0);
    checkHazard("lu_invalid", 1'b0, 1'b0);
    stepClock();
    flushPipe();

    // Freeze during a load-use stall: ADD r2; LW r5,(r2); ADD r5
    applyStimulus(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    stepClock();
    checkDeciders("frz_pre", 2'd1, 2'd0);
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b0);
    checkHazard("frz_hit", 1'b1, 1'b1);
    pipe_freeze = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkHazard("frz_hold", 1'b1, 1'b0);
      stepClock();
      checkDeciders("frz_hold", 2'd1, 2'd0);
      @(negedge clk);
      #1;
    end
    pipe_freeze = 1'b0;
    #1;
    checkHazard("frz_after", 1'b1, 1'b1);
    stepClock();
    checkDeciders("frz_bubble", 2'd0, 2'd0);
    checkHazard("frz_release", 1'b0, 1'b0);
    stepClock();
    checkDeciders("frz_enter", 2'd2, 2'd0);

    // Asynchronous reset clears a live forward select immediately
    rst = 1'b0;
    #1;
    checkDeciders("rst_fwd", 2'd0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    flushPipe();

    // Forwarding disabled: ADD r6; reader of r6 stalls until r6 is in WB
    fwd_en = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd6, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0);
    checkHazard("raw_ex", 1'b1, 1'b1);
    stepClock();
    checkDeciders("raw_bubble", 2'd0, 2'd0);
    checkHazard("raw_mem", 1'b1, 1'b1);
    stepClock();
    checkHazard("raw_wb", 1'b0, 1'b0);
    stepClock();
    checkDeciders("raw_enter", 2'd0, 2'd0);
    flushPipe();

    // Reset while in RAW_STALL aborts the stall
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd6, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0);
    stepClock();
    checkHazard("rst_raw_pre", 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    checkHazard("rst_raw", 1'b0, 1'b0);
    checkDeciders("rst_raw", 2'd0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkHazard("rst_run", 1'b0, 1'b0);
    stepClock();
    checkHazard("rst_run2", 1'b0, 1'b0);
    fwd_en = 1'b1;
    flushPipe();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
